// File: rtl/bcd_complement_seq_pkg.sv
// bcd_pkg: shared types and constants for the digit-serial BCD complementer.
//   state_t  - controller states (IDLE, RUN, DONE)
//   digit_t  - one 4-bit BCD digit
//   BCD_NINE - constant 9, the minuend of the 9's complement
//   BCD_TEN  - constant 10, the digit overflow value
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t     BCD_NINE = 4'd9;
  localparam logic [4:0] BCD_TEN  = 5'd10;

endpackage

// File: rtl/bcd_complement_seq_if.sv
// bcd_complement_seq_if: start/done handshake and operand/result bus.
//   start, mode, bcd_in          - driven by the requester (master)
//   busy, done, result, cout,
//   invalid                      - driven by the complementer (slave)
interface bcd_complement_seq_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  mode;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  invalid;

  modport master (
    output start, mode, bcd_in,
    input  busy, done, result, cout, invalid
  );

  modport slave (
    input  start, mode, bcd_in,
    output busy, done, result, cout, invalid
  );
endinterface

// File: rtl/bcd_complement_seq_digit_comp.sv
// bcd_digit_comp: combinational single-digit 9's/10's complement stage.
//   digit     - input BCD digit
//   cin       - incoming decimal carry (adds 1 to 9 - digit)
//   check     - enables the digit > 9 detector
//   out_digit - complemented digit
//   cout      - decimal carry out (sum reached ten)
//   bad       - digit was not valid BCD (only when check = 1)
module bcd_digit_comp
  import bcd_pkg::*;
(
  input  digit_t digit,
  input  logic   cin,
  input  logic   check,
  output digit_t out_digit,
  output logic   cout,
  output logic   bad
);

  digit_t     d9;
  logic [4:0] s;

  always_comb begin
    // 4-bit wrap is intentional: non-BCD digits are not range-corrected.
    d9 = BCD_NINE - digit;
    s  = {1'b0, d9} + {4'b0000, cin};
    if (s == BCD_TEN) begin
      out_digit = '0;
      cout      = 1'b1;
    end else begin
      out_digit = s[3:0];
      cout      = 1'b0;
    end
    bad = check && (digit > BCD_NINE);
  end

endmodule

// File: rtl/bcd_complement_seq.sv
// bcd_complement_seq: digit-serial 9's / 10's complement of a packed BCD
// operand, one digit per clock, least-significant digit first.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of bcd_complement_seq_if (start/mode/bcd_in in,
//          busy/done/result/cout/invalid out)
// Optional feature macro: BCD_CHECK_EN builds the non-BCD digit detector
// and a sticky invalid flag; without it invalid is constant 0.
module bcd_complement_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input logic                 clk,
  input logic                 rst,
  bcd_complement_seq_if.slave bus
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t        state, state_next;
  logic [CW-1:0] idx;
  logic [W-1:0]  work, work_next;
  logic          mode_r;
  logic          carry;
  logic          accept;
  logic          last;
  logic          cin;
  logic          check;
  digit_t        out_digit;
  logic          dcout;
  logic          dbad;

  assign cin = carry & mode_r;

`ifdef BCD_CHECK_EN
  logic inv_r;
  assign check       = 1'b1;
  assign bus.invalid = inv_r;
`else
  // check is tied low, so dbad is a constant 0 and no comparator remains.
  assign check       = 1'b0;
  assign bus.invalid = dbad;
`endif

  bcd_digit_comp u_digit (
    .digit     (work[3:0]),
    .cin       (cin),
    .check     (check),
    .out_digit (out_digit),
    .cout      (dcout),
    .bad       (dbad)
  );

  // Right shift: the next digit moves into the low nibble, the finished
  // digit enters at the top, so after DIGITS shifts work holds the result.
  always_comb begin
    work_next          = work >> 4;
    work_next[W-1 -: 4] = out_digit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = (idx == LAST);
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  // result/cout are loaded on the final RUN edge so they are valid in the
  // same cycle that done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      work       <= '0;
      mode_r     <= 1'b0;
      carry      <= 1'b0;
      bus.result <= '0;
      bus.cout   <= 1'b0;
`ifdef BCD_CHECK_EN
      inv_r      <= 1'b0;
`endif
    end else if (accept) begin
      idx    <= '0;
      work   <= bus.bcd_in;
      mode_r <= bus.mode;
      carry  <= bus.mode;
`ifdef BCD_CHECK_EN
      inv_r  <= 1'b0;
`endif
    end else if (state == RUN) begin
      work  <= work_next;
      carry <= dcout;
      idx   <= idx + CW'(1);
`ifdef BCD_CHECK_EN
      inv_r <= inv_r | dbad;
`endif
      if (last) begin
        bus.result <= work_next;
        bus.cout   <= dcout & mode_r;
      end
    end
  end

endmodule

// File: tb/tb_bcd_complement_seq.sv
// tb_bcd_complement_seq: directed self-checking bench for bcd_complement_seq
// with DIGITS = 4. Inputs change and outputs are sampled on the falling edge.
module tb_bcd_complement_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  bcd_complement_seq_if #(.DIGITS(4)) bus ();

  bcd_complement_seq #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef BCD_CHECK_EN
  localparam logic INV_EXP = 1'b1;
`else
  localparam logic INV_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called on a falling edge: present a request.
  task automatic launch(input logic m, input logic [15:0] v);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.bcd_in = v;
  endtask

  // Accept edge, then four busy cycles, then the done cycle (ends at the
  // falling edge of the done cycle so a back-to-back launch can follow).
  task automatic expect_op(input string tag, input logic [15:0] exp_r,
                           input logic exp_c, input logic exp_inv);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      check({tag, " no done"}, 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy low"}, 32'(bus.busy), 32'd0);
    check({tag, " result"}, 32'(bus.result), 32'(exp_r));
    check({tag, " cout"}, 32'(bus.cout), 32'(exp_c));
    check({tag, " invalid"}, 32'(bus.invalid), 32'(exp_inv));
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus.bcd_in = '0;

    #2;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst result", 32'(bus.result), 32'd0);
    check("rst cout", 32'(bus.cout), 32'd0);
    check("rst invalid", 32'(bus.invalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 9's complement
    launch(1'b0, 16'h1234);
    expect_op("nines 1234", 16'h8765, 1'b0, 1'b0);
    @(negedge clk);
    check("idle after done", 32'(bus.done), 32'd0);

    // 10's complement with carry ripple and the all-zero carry out
    launch(1'b1, 16'h0990);
    expect_op("tens 0990", 16'h9010, 1'b0, 1'b0);
    @(negedge clk);
    launch(1'b1, 16'h0000);
    expect_op("tens 0000", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);

    // back-to-back: start held through DONE
    launch(1'b1, 16'h9999);
    expect_op("tens 9999", 16'h0001, 1'b0, 1'b0);
    launch(1'b0, 16'h0001);
    expect_op("b2b 0001", 16'h9998, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b then idle", 32'(bus.done), 32'd0);

    // start during RUN is ignored; mode/bcd_in changes have no effect
    launch(1'b0, 16'h1234);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    launch(1'b1, 16'h5555);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ignored done", 32'(bus.done), 32'd1);
    check("ignored result", 32'(bus.result), 32'h8765);
    check("ignored cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    check("no queued run", 32'(bus.busy), 32'd0);
    @(negedge clk);

    // reset mid-run (previous result 8765 must be cleared at once)
    launch(1'b1, 16'h0000);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort result", 32'(bus.result), 32'd0);
    check("abort cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post-abort quiet", 32'(bus.done | bus.busy), 32'd0);
    end
    launch(1'b0, 16'h0990);
    expect_op("post-abort 0990", 16'h9009, 1'b0, 1'b0);
    @(negedge clk);

    // non-BCD digit: 4-bit rule, A -> F
    launch(1'b0, 16'h12A4);
    expect_op("nonbcd 12A4", 16'h87F5, 1'b0, INV_EXP);
    @(negedge clk);
    launch(1'b1, 16'h0001);
    expect_op("clear inv 0001", 16'h9999, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
